// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that feeds one shared sign-magnitude multiplier pipeline
// and routes each product back to the requester that issued it.
module mult_share_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PIPE_LAT   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_b,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    input  logic                               i_hold,
    output logic                               o_issue_valid,
    output logic [DATA_WIDTH-2:0]              o_mag_a,
    output logic [DATA_WIDTH-2:0]              o_mag_b,
    output logic                               o_sign,
    input  logic [31:0]                        i_result,
    output logic [NUM_REQ-1:0]                 o_res_valid,
    output logic [31:0]                        o_res_data,
    output logic [$clog2(PIPE_LAT+2)-1:0]      o_inflight
);

    localparam int unsigned TAG_W = $clog2(NUM_REQ);
    localparam int unsigned MAG_W = DATA_WIDTH - 1;
    localparam int unsigned INF_W = $clog2(PIPE_LAT + 2);

    logic [TAG_W-1:0]      last;
    logic [TAG_W-1:0]      cand;
    logic [TAG_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [MAG_W-1:0]      mag_a_c;
    logic [MAG_W-1:0]      mag_b_c;
    logic                  sign_c;
    logic [TAG_W-1:0]      issue_tag;
    logic [PIPE_LAT-1:0]   stage_vld;
    logic [TAG_W-1:0]      stage_tag [PIPE_LAT];
    logic                  deliver;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        cand        = last;
        grant_idx   = last;
        grant_any   = 1'b0;
        o_req_ready = '0;
        if (!rst && !i_hold) begin
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                cand = TAG_W'((32'(last) + off) % NUM_REQ);
                if (!grant_any && i_req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) o_req_ready[grant_idx] = 1'b1;
    end

    // Negative-zero operands must come out as +0, so a zero magnitude kills the sign.
    always_comb begin
        sel_a   = i_req_a[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_b   = i_req_b[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        mag_a_c = sel_a[MAG_W-1:0];
        mag_b_c = sel_b[MAG_W-1:0];
        sign_c  = (sel_a[DATA_WIDTH-1] ^ sel_b[DATA_WIDTH-1]) & (|mag_a_c) & (|mag_b_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_issue_valid <= 1'b0;
            o_mag_a       <= '0;
            o_mag_b       <= '0;
            o_sign        <= 1'b0;
            issue_tag     <= '0;
            last          <= TAG_W'(NUM_REQ - 1);
        end else begin
            o_issue_valid <= grant_any;
            if (grant_any) begin
                o_mag_a   <= mag_a_c;
                o_mag_b   <= mag_b_c;
                o_sign    <= sign_c;
                issue_tag <= grant_idx;
                last      <= grant_idx;
            end
        end
    end

    // Tag shadow pipeline, aligned with the datapath latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++) stage_tag[i] <= '0;
        end else begin
            stage_vld[0] <= o_issue_valid;
            stage_tag[0] <= issue_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stage_vld[i] <= stage_vld[i-1];
                stage_tag[i] <= stage_tag[i-1];
            end
        end
    end

    assign deliver = stage_vld[PIPE_LAT-1];

    // The count drops on the same edge that raises the result strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_res_valid <= '0;
            o_res_data  <= '0;
            o_inflight  <= '0;
        end else begin
            o_res_valid <= '0;
            if (deliver) begin
                o_res_valid[stage_tag[PIPE_LAT-1]] <= 1'b1;
                o_res_data <= i_result;
            end
            case ({grant_any, deliver})
                2'b10:   o_inflight <= o_inflight + INF_W'(1);
                2'b01:   o_inflight <= o_inflight - INF_W'(1);
                default: o_inflight <= o_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a 2-cycle datapath model.
module tb_mult_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int LAT     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ*DW-1:0]   i_req_a;
    logic [NUM_REQ*DW-1:0]   i_req_b;
    logic [NUM_REQ-1:0]      o_req_ready;
    logic                    i_hold;
    logic                    o_issue_valid;
    logic [DW-2:0]           o_mag_a;
    logic [DW-2:0]           o_mag_b;
    logic                    o_sign;
    logic [31:0]             i_result;
    logic [NUM_REQ-1:0]      o_res_valid;
    logic [31:0]             o_res_data;
    logic [1:0]              o_inflight;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .i_req_a(i_req_a),
        .i_req_b(i_req_b), .o_req_ready(o_req_ready), .i_hold(i_hold),
        .o_issue_valid(o_issue_valid), .o_mag_a(o_mag_a), .o_mag_b(o_mag_b),
        .o_sign(o_sign), .i_result(i_result), .o_res_valid(o_res_valid),
        .o_res_data(o_res_data), .o_inflight(o_inflight)
    );

    typedef struct { int tag; logic [31:0] res; int cyc; } res_exp_t;
    typedef struct { logic [14:0] ma; logic [14:0] mb; logic s; int cyc; } iss_exp_t;

    res_exp_t    sb [$];
    iss_exp_t    iq [$];
    logic [31:0] opq [NUM_REQ][$];
    int          grant_log [$];
    int          grant_cyc [$];
    int          res_log [$];
    int          res_cyc [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_m   = NUM_REQ - 1;
    int max_inf  = 0;

    logic [14:0]        last_ma, last_mb;
    logic               last_s;
    logic [31:0]        last_res_data;
    logic [NUM_REQ-1:0] last_res_valid;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [31:0]        dp1, dp2;
    logic [31:0]        op;
    iss_exp_t           ie;
    res_exp_t           re;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sm_prod(input logic [14:0] ma, input logic [14:0] mb, input logic s);
        logic [31:0] p;
        p = 32'(ma) * 32'(mb);
        return s ? (32'd0 - p) : p;
    endfunction

    // Datapath model: registered product two cycles after issue.
    always @(posedge clk) begin
        dp1 <= sm_prod(o_mag_a, o_mag_b, o_sign);
        dp2 <= dp1;
    end
    assign i_result = dp2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_rdy = '0;
        if (!rst && !i_hold) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                int j;
                j = (last_m + off) % NUM_REQ;
                if (i_req_valid[j]) begin
                    exp_rdy[j] = 1'b1;
                    break;
                end
            end
        end
        check("ready", 64'(o_req_ready), 64'(exp_rdy));

        if (o_issue_valid === 1'b1) begin
            if (iq.size() == 0) check("issue_spurious", 64'(1), 64'(0));
            else begin
                ie = iq.pop_front();
                check("issue_mag_a", 64'(o_mag_a), 64'(ie.ma));
                check("issue_mag_b", 64'(o_mag_b), 64'(ie.mb));
                check("issue_sign", 64'(o_sign), 64'(ie.s));
                check("issue_lat", 64'(cyc - ie.cyc), 64'(1));
                last_ma = o_mag_a; last_mb = o_mag_b; last_s = o_sign;
            end
        end

        if (o_res_valid !== '0) begin
            if (sb.size() == 0) check("res_spurious", 64'(o_res_valid), 64'(0));
            else begin
                re = sb.pop_front();
                check("res_strobe", 64'(o_res_valid), 64'(1) << re.tag);
                check("res_data", 64'(o_res_data), 64'(re.res));
                check("res_lat", 64'(cyc - re.cyc), 64'(LAT + 2));
                res_log.push_back(re.tag);
                res_cyc.push_back(cyc);
                last_res_data = o_res_data; last_res_valid = o_res_valid;
            end
        end else if (sb.size() > 0 && cyc - sb[0].cyc >= LAT + 2) begin
            check("res_missing", 64'(0), 64'(1));
            void'(sb.pop_front());
        end

        check("inflight", 64'(o_inflight), 64'(sb.size()));
        if (int'(o_inflight) > max_inf) max_inf = int'(o_inflight);

        if (rst) begin
            sb.delete();
            iq.delete();
            last_m = NUM_REQ - 1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (i_req_valid[k] && o_req_ready[k]) begin
                    op = opq[k].pop_front();
                    ie.ma = op[30:16];
                    ie.mb = op[14:0];
                    ie.s  = (op[31] ^ op[15]) && (op[30:16] != 0) && (op[14:0] != 0);
                    ie.cyc = cyc;
                    iq.push_back(ie);
                    re.tag = k;
                    re.res = sm_prod(ie.ma, ie.mb, ie.s);
                    re.cyc = cyc;
                    sb.push_back(re);
                    grant_log.push_back(k);
                    grant_cyc.push_back(cyc);
                    last_m = k;
                end
            end
        end
    end

    task automatic tick();
        for (int k = 0; k < NUM_REQ; k++) begin
            i_req_valid[k] = (opq[k].size() > 0);
            if (opq[k].size() > 0) begin
                i_req_a[k*DW +: DW] = opq[k][0][31:16];
                i_req_b[k*DW +: DW] = opq[k][0][15:0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() > 0 || iq.size() > 0 || opq[0].size() > 0 || opq[1].size() > 0 ||
                opq[2].size() > 0 || opq[3].size() > 0) && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 64'(0), 64'(1));
        tick();
    endtask

    function automatic logic [31:0] rand_op();
        return {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, r0, guard;
        rst = 1'b1; i_hold = 1'b0; i_req_valid = '0; i_req_a = '0; i_req_b = '0;
        repeat (3) tick();
        check("rst_issue_valid", 64'(o_issue_valid), 64'(0));
        check("rst_res_valid", 64'(o_res_valid), 64'(0));
        check("rst_inflight", 64'(o_inflight), 64'(0));
        check("rst_ready", 64'(o_req_ready), 64'(0));
        rst = 1'b0;

        // Single op from requester 2
        opq[2].push_back({16'h8003, 16'h0005});
        drain();
        check("single_grant", 64'(grant_log[grant_log.size()-1]), 64'(2));
        check("single_mag_a", 64'(last_ma), 64'(3));
        check("single_mag_b", 64'(last_mb), 64'(5));
        check("single_sign", 64'(last_s), 64'(1));
        check("single_res_valid", 64'(last_res_valid), 64'(4'b0100));
        check("single_res_data", 64'(last_res_data), 64'(32'hFFFFFFF1));

        // Negative zero
        opq[0].push_back({16'h8000, 16'h8007});
        drain();
        check("nz_sign", 64'(last_s), 64'(0));
        check("nz_mag_a", 64'(last_ma), 64'(0));
        check("nz_res", 64'(last_res_data), 64'(0));

        // Round-robin from reset with all requesters valid
        rst = 1'b1;
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < 6; i++) opq[k].push_back(rand_op());
        repeat (2) tick();
        g0 = grant_log.size(); r0 = res_log.size(); max_inf = 0;
        rst = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) begin
            check("rr_grant", 64'(grant_log[g0+i]), 64'(i % NUM_REQ));
            check("rr_res_order", 64'(res_log[r0+i]), 64'(i % NUM_REQ));
        end
        check("rr_grant_gap", 64'(grant_cyc[g0+7] - grant_cyc[g0]), 64'(7));
        check("rr_max_inflight", 64'(max_inf), 64'(LAT + 1));

        // Hold with requesters 1 and 3 waiting
        opq[1].push_back(rand_op());
        g0 = grant_log.size(); r0 = res_log.size();
        guard = 0;
        while (grant_log.size() == g0 && guard < 20) begin tick(); guard++; end
        i_hold = 1'b1;
        opq[1].push_back(rand_op());
        opq[3].push_back(rand_op());
        repeat (3) begin
            tick();
            check("hold_no_grant", 64'(grant_log.size()), 64'(g0 + 1));
        end
        i_hold = 1'b0;
        tick();
        check("hold_res_delivered", 64'(res_log.size()), 64'(r0 + 1));
        check("hold_resume_grant", 64'(grant_log[grant_log.size()-1]), 64'(3));
        drain();

        // Reset one cycle after two issues
        opq[0].push_back(rand_op());
        opq[2].push_back(rand_op());
        g0 = grant_log.size();
        guard = 0;
        while (grant_log.size() < g0 + 2 && guard < 20) begin tick(); guard++; end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_inflight", 64'(o_inflight), 64'(0));
        r0 = res_log.size();
        g0 = grant_log.size();
        opq[3].push_back(rand_op());
        opq[0].push_back(rand_op());
        tick();
        check("midrst_first_grant", 64'(grant_log[g0]), 64'(0));
        repeat (2) tick();
        check("midrst_no_strobe", 64'(res_log.size()), 64'(r0));
        drain();

        // Single requester streaming
        for (int i = 0; i < 6; i++) opq[1].push_back(rand_op());
        g0 = grant_log.size(); r0 = res_log.size();
        drain();
        for (int i = 0; i < 6; i++) begin
            check("stream_grant", 64'(grant_log[g0+i]), 64'(1));
            check("stream_res", 64'(res_log[r0+i]), 64'(1));
        end
        check("stream_grant_gap", 64'(grant_cyc[g0+5] - grant_cyc[g0]), 64'(5));
        check("stream_res_gap", 64'(res_cyc[r0+5] - res_cyc[r0]), 64'(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
